// File: rtl/display_scan.sv
// display_scan: text-mode scan-out; fetches char codes from display RAM port B,
//   looks up glyph rows in the character ROM and serialises them into pixels.
// Latency: 4 clk from RAM address to next_bits valid; pixel/pixel_de 1 pix_ce behind active.
// Backpressure: none; a glyph that is not ready at a cell boundary renders as a blank cell.
// Ports: clk/reset (async, active-high); pix_ce/frame_start/line_start/active from timing;
//   ram_adb/ram_ceb/ram_oceb/ram_doutb = display RAM port B (2-clk pipelined read);
//   rom_addr/rom_data = character ROM (1-clk read); pixel/pixel_de = serial video out.
// Optional: define DISPLAY_SCAN_GFX_EN for built-in 2x3 block graphics on codes 0x80-0xFF.
module display_scan #(
    parameter int COLS   = 64,
    parameter int ROWS   = 16,
    parameter int CHAR_W = 6,
    parameter int CHAR_H = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        pix_ce,
    input  logic        frame_start,
    input  logic        line_start,
    input  logic        active,
    output logic [9:0]  ram_adb,
    output logic        ram_ceb,
    output logic        ram_oceb,
    input  logic [7:0]  ram_doutb,
    output logic [10:0] rom_addr,
    input  logic [7:0]  rom_data,
    output logic        pixel,
    output logic        pixel_de
);
    localparam int COL_W      = $clog2(COLS);
    localparam int ROW_W      = $clog2(ROWS);
    localparam int CNT_W      = $clog2(CHAR_W);
    localparam int CNT_LAST_I = CHAR_W - 1;

    localparam logic [COL_W:0]   COL_END  = COLS[COL_W:0];
    localparam logic [COL_W:0]   COL_ONE  = {{COL_W{1'b0}}, 1'b1};
    localparam logic [ROW_W:0]   ROW_END  = ROWS[ROW_W:0];
    localparam logic [ROW_W:0]   ROW_ONE  = {{ROW_W{1'b0}}, 1'b1};
    localparam logic [3:0]       LIC_LAST = 4'(CHAR_H - 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_LAST_I[CNT_W-1:0];
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_WAIT, S_ROM, S_LOAD} state_t;

    state_t            state_q, state_d;
    logic [3:0]        lic_q, lic_d;
    logic [ROW_W:0]    row_q, row_d;
    logic [COL_W:0]    col_q, col_d;
    logic              frame_pend_q, frame_pend_d;
    logic [7:0]        code_q, code_d;
    logic [CHAR_W-1:0] next_bits_q, next_bits_d;
    logic              nb_vld_q, nb_vld_d;
    logic [CHAR_W-1:0] shift_q, shift_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              pixel_q, pixel_d;
    logic              pixel_de_q, pixel_de_d;

    logic [CHAR_W-1:0] glyph_bits;
    logic [CHAR_W-1:0] load_bits;
    logic [7:0]        code_cur;

    // RAM strobes are decoded straight from the state flops so an async reset drops them at once.
    assign ram_adb  = {row_q[ROW_W-1:0], col_q[COL_W-1:0]};
    assign ram_ceb  = (state_q == S_ADDR);
    assign ram_oceb = (state_q == S_WAIT);
    // In ROM the code is taken directly off the RAM output so rom_data is ready during LOAD.
    assign code_cur = (state_q == S_ROM) ? ram_doutb : code_q;
    assign rom_addr = {code_cur[6:0], lic_q};
    assign pixel    = pixel_q;
    assign pixel_de = pixel_de_q;

`ifdef DISPLAY_SCAN_GFX_EN
    localparam int         HALF_W = CHAR_W / 2;
    localparam logic [3:0] LIC_B1 = 4'(CHAR_H / 3);
    localparam logic [3:0] LIC_B2 = 4'(2 * (CHAR_H / 3));

    logic [1:0] band;
    logic       left_on;
    logic       right_on;

    // Band 0/1/2 = top/middle/bottom third; code bits {2b+1, 2b} are its right/left blocks.
    always_comb begin
        band = 2'd0;
        if (lic_q >= LIC_B2) begin
            band = 2'd2;
        end else if (lic_q >= LIC_B1) begin
            band = 2'd1;
        end
        left_on    = code_q[{band, 1'b0}];
        right_on   = code_q[{band, 1'b1}];
        glyph_bits = code_q[7] ? {{HALF_W{left_on}}, {(CHAR_W - HALF_W){right_on}}}
                               : rom_data[7 -: CHAR_W];
    end

    logic unused_rom_bits;
    assign unused_rom_bits = ^rom_data[7-CHAR_W:0];
`else
    assign glyph_bits = rom_data[7 -: CHAR_W];

    logic unused_bits;
    assign unused_bits = ^{rom_data[7-CHAR_W:0], code_q[7]};
`endif

    always_comb begin
        state_d      = state_q;
        lic_d        = lic_q;
        row_d        = row_q;
        col_d        = col_q;
        frame_pend_d = frame_pend_q;
        code_d       = code_q;
        next_bits_d  = next_bits_q;
        nb_vld_d     = nb_vld_q;
        shift_d      = shift_q;
        cnt_d        = cnt_q;
        pixel_d      = 1'b0;
        pixel_de_d   = active & pix_ce;
        load_bits    = nb_vld_q ? next_bits_q : '0;

        // Shifter. cnt_q==0 marks a cell boundary (also the first pixel of a line): the new
        // cell's first pixel comes straight from next_bits and the next fetch is launched.
        if (active && pix_ce) begin
            if (cnt_q == '0) begin
                pixel_d  = load_bits[CHAR_W-1];
                shift_d  = load_bits << 1;
                cnt_d    = CNT_LAST;
                nb_vld_d = 1'b0;
                if (state_q == S_IDLE && col_q != COL_END && row_q != ROW_END) begin
                    state_d = S_ADDR;
                end
            end else begin
                pixel_d = shift_q[CHAR_W-1];
                shift_d = shift_q << 1;
                cnt_d   = cnt_q - CNT_ONE;
            end
        end

        // Fetch pipeline; placed after the shifter so a LOAD always marks next_bits valid.
        case (state_q)
            S_ADDR: state_d = S_WAIT;
            S_WAIT: state_d = S_ROM;
            S_ROM: begin
                code_d  = ram_doutb;
                state_d = S_LOAD;
            end
            S_LOAD: begin
                next_bits_d = glyph_bits;
                nb_vld_d    = 1'b1;
                col_d       = col_q + COL_ONE;
                state_d     = S_IDLE;
            end
            default: ;
        endcase

        // Line/frame strobes override everything: drop any fetch in flight and restart at col 0.
        if (frame_start || line_start) begin
            state_d     = S_IDLE;
            col_d       = '0;
            nb_vld_d    = 1'b0;
            next_bits_d = '0;
            cnt_d       = '0;
        end
        if (frame_start) begin
            lic_d        = '0;
            row_d        = '0;
            frame_pend_d = 1'b1;
        end
        if (line_start) begin
            if (frame_start || frame_pend_q) begin
                lic_d        = '0;
                row_d        = '0;
                frame_pend_d = 1'b0;
            end else if (row_q != ROW_END) begin
                if (lic_q == LIC_LAST) begin
                    lic_d = '0;
                    row_d = row_q + ROW_ONE;
                end else begin
                    lic_d = lic_q + 4'd1;
                end
            end
            // Prefetch column 0 unless we are in the blank region below the last text row.
            if (row_d != ROW_END) begin
                state_d = S_ADDR;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_IDLE;
            lic_q        <= '0;
            row_q        <= '0;
            col_q        <= '0;
            frame_pend_q <= 1'b0;
            code_q       <= '0;
            next_bits_q  <= '0;
            nb_vld_q     <= 1'b0;
            shift_q      <= '0;
            cnt_q        <= '0;
            pixel_q      <= 1'b0;
            pixel_de_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            lic_q        <= lic_d;
            row_q        <= row_d;
            col_q        <= col_d;
            frame_pend_q <= frame_pend_d;
            code_q       <= code_d;
            next_bits_q  <= next_bits_d;
            nb_vld_q     <= nb_vld_d;
            shift_q      <= shift_d;
            cnt_q        <= cnt_d;
            pixel_q      <= pixel_d;
            pixel_de_q   <= pixel_de_d;
        end
    end
endmodule

// File: tb/tb_display_scan.sv
// Testbench for display_scan: RAM/ROM behavioural memories, randomized content and pix_ce,
// expected pixels derived from screen geometry (line -> text row/cell line, pixel -> column/bit).
module tb_display_scan;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        pix_ce = 1'b1;
    logic        frame_start = 1'b0;
    logic        line_start = 1'b0;
    logic        active = 1'b0;
    logic [9:0]  ram_adb;
    logic        ram_ceb;
    logic        ram_oceb;
    logic [7:0]  ram_doutb = 8'h00;
    logic [10:0] rom_addr;
    logic [7:0]  rom_data = 8'h00;
    logic        pixel;
    logic        pixel_de;

    int n_checks = 0;
    int n_fail   = 0;
    int cur_line = -1;

    logic [7:0] ram [0:1023];
    logic [7:0] rom [0:2047];
    logic [7:0] ram_s1 = 8'h00;

    logic       pix_q[$];
    logic [9:0] adb_q[$];
    int         ceb_cnt = 0;
    int         lit_cnt = 0;
    int         de_cnt = 0;
    bit         saw_rom010 = 0;

    display_scan dut (
        .clk(clk), .reset(reset), .pix_ce(pix_ce), .frame_start(frame_start),
        .line_start(line_start), .active(active), .ram_adb(ram_adb), .ram_ceb(ram_ceb),
        .ram_oceb(ram_oceb), .ram_doutb(ram_doutb), .rom_addr(rom_addr),
        .rom_data(rom_data), .pixel(pixel), .pixel_de(pixel_de)
    );

    always #5 clk = ~clk;

    // Display RAM: address registered with ceb, output register loaded with oceb.
    always @(posedge clk) begin
        if (ram_ceb) ram_s1 <= ram[ram_adb];
        if (ram_oceb) ram_doutb <= ram_s1;
        rom_data <= rom[rom_addr];
    end

    always @(negedge clk) begin
        if (pixel_de) begin
            pix_q.push_back(pixel);
            de_cnt++;
        end
        if (pixel) lit_cnt++;
        if (ram_ceb) begin
            ceb_cnt++;
            adb_q.push_back(ram_adb);
        end
        if (rom_addr == 11'h010) saw_rom010 = 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish, checks=%0d", n_checks);
        $fatal(1, "timeout");
    end

    // Reference: scan line s shows text row s/12, cell line s%12; pixel p is column p/6, bit p%6.
    function automatic logic exp_pix(input int s, input int p);
        int row, lic, c, k, code, g;
        row = s / 12;
        lic = s % 12;
        if (row >= 16) return 1'b0;
        c = p / 6;
        k = p % 6;
        code = int'(ram[row * 64 + c]);
`ifdef DISPLAY_SCAN_GFX_EN
        if (code >= 128) begin
            int band;
            band = lic / 4;
            if (band > 2) band = 2;
            g = (k < 3) ? (code >> (2 * band)) : (code >> (2 * band + 1));
            return g[0];
        end
`endif
        g = int'(rom[(code % 128) * 16 + lic]);
        return g[7 - k];
    endfunction

    function automatic int line_errs(input int s);
        int e;
        e = 0;
        if (pix_q.size() != 384) return -1;
        for (int p = 0; p < 384; p++) if (pix_q[p] !== exp_pix(s, p)) e++;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fill_mem(input bit rnd, input logic [7:0] ram_val, input logic [7:0] rom_val);
        for (int i = 0; i < 1024; i++) ram[i] = rnd ? 8'($urandom) : ram_val;
        for (int i = 0; i < 2048; i++) rom[i] = rnd ? 8'($urandom) : rom_val;
    endtask

    task automatic do_frame;
        frame_start = 1'b1;
        tick;
        frame_start = 1'b0;
        tick;
        cur_line = -1;
    endtask

    // One scan line; optional abort (second line_start 2 clk into the col-0 fetch) and
    // optional frame_start coincident with line_start. Collects outputs via the monitor.
    task automatic do_line(input bit show, input bit rand_ce, input bit abort, input bit with_frame);
        int n, cyc;
        line_start  = 1'b1;
        frame_start = with_frame;
        tick;
        line_start  = 1'b0;
        frame_start = 1'b0;
        if (abort) begin
            tick;
            line_start = 1'b1;
            tick;
            line_start = 1'b0;
        end
        pix_q.delete();
        adb_q.delete();
        ceb_cnt = 0; lit_cnt = 0; de_cnt = 0; saw_rom010 = 0;
        if (!show) begin
            repeat (8) tick;
            return;
        end
        repeat (7) tick;
        active = 1'b1;
        n = 0;
        cyc = 0;
        while (n < 384 && cyc < 4000) begin
            pix_ce = rand_ce ? ($urandom_range(0, 3) != 0) : 1'b1;
            if (pix_ce) n++;
            tick;
            cyc++;
        end
        active = 1'b0;
        pix_ce = 1'b1;
        repeat (4) tick;
    endtask

    task automatic advance_to(input int s);
        while (cur_line < s - 1) begin
            cur_line++;
            do_line(0, 0, 0, 0);
        end
    endtask

    task automatic test_reset;
        reset = 1'b1;
        repeat (3) tick;
        n_checks++;
        if ({pixel, pixel_de, ram_ceb, ram_oceb} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_strobes: got %b want 0000", {pixel, pixel_de, ram_ceb, ram_oceb});
        end
        n_checks++;
        if (ram_adb !== 10'd0) begin
            n_fail++;
            $display("FAIL reset_ram_adb: got %0d want 0", ram_adb);
        end
        n_checks++;
        if (rom_addr !== 11'd0) begin
            n_fail++;
            $display("FAIL reset_rom_addr: got %0h want 0", rom_addr);
        end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_blank_frame;
        fill_mem(1, 8'h00, 8'h00);
        for (int i = 0; i < 1024; i++) ram[i] = 8'h20;
        for (int l = 0; l < 16; l++) rom[32 * 16 + l] = 8'h00;
        do_frame;
        for (int s = 0; s < 192; s++) begin
            bit show;
            show = (s % 32 == 0) || (s == 191);
            cur_line++;
            do_line(show, 0, 0, 0);
            if (show) begin
                n_checks++;
                if (de_cnt !== 384) begin
                    n_fail++;
                    $display("FAIL blank_de_count line %0d: got %0d want 384", s, de_cnt);
                end
                n_checks++;
                if (lit_cnt !== 0) begin
                    n_fail++;
                    $display("FAIL blank_lit line %0d: got %0d lit pixels want 0", s, lit_cnt);
                end
                n_checks++;
                if (ceb_cnt !== 64) begin
                    n_fail++;
                    $display("FAIL blank_reads line %0d: got %0d want 64", s, ceb_cnt);
                end
            end
        end
    endtask

    // Continues from the blank frame: scan lines 192 and 193 sit below the last text row.
    task automatic test_row_saturate;
        fill_mem(1, 8'h00, 8'h00);
        for (int k = 0; k < 2; k++) begin
            cur_line++;
            do_line(1, 1, 0, 0);
            n_checks++;
            if (ceb_cnt !== 0 || lit_cnt !== 0) begin
                n_fail++;
                $display("FAIL saturate line %0d: reads=%0d lit=%0d want 0/0", cur_line, ceb_cnt, lit_cnt);
            end
            n_checks++;
            if (de_cnt !== 384) begin
                n_fail++;
                $display("FAIL saturate_de line %0d: got %0d want 384", cur_line, de_cnt);
            end
        end
    endtask

    task automatic test_char_a;
        logic [29:0] got3, want3;
        logic [5:0]  got6;
        fill_mem(0, 8'h20, 8'h00);
        ram[0] = 8'h41;
        rom[8'h41 * 16] = 8'h70;
        do_frame;
        cur_line++;
        do_line(1, 0, 0, 0);
        want3 = {10'd0, 10'd1, 10'd2};
        got3 = '1;
        if (adb_q.size() >= 3) got3 = {adb_q[0], adb_q[1], adb_q[2]};
        n_checks++;
        if (got3 !== want3) begin
            n_fail++;
            $display("FAIL char_a_addr: got %h want %h", got3, want3);
        end
        got6 = 'x;
        for (int i = 0; i < 6; i++) if (pix_q.size() > i) got6[5 - i] = pix_q[i];
        n_checks++;
        if (got6 !== 6'b011100) begin
            n_fail++;
            $display("FAIL char_a_pixels: got %b want 011100", got6);
        end
        n_checks++;
        if (lit_cnt !== 3) begin
            n_fail++;
            $display("FAIL char_a_lit: got %0d want 3", lit_cnt);
        end
    endtask

    task automatic test_gfx_code;
        logic [5:0] got6, want6;
        fill_mem(0, 8'h20, 8'h00);
        rom[16] = 8'hA8;
        ram[64] = 8'h81;
`ifdef DISPLAY_SCAN_GFX_EN
        want6 = 6'b111000;
`else
        want6 = 6'b101010;
`endif
        do_frame;
        advance_to(12);
        cur_line++;
        do_line(1, 0, 0, 0);
        got6 = 'x;
        for (int i = 0; i < 6; i++) if (pix_q.size() > i) got6[5 - i] = pix_q[i];
        n_checks++;
        if (got6 !== want6) begin
            n_fail++;
            $display("FAIL gfx_pixels: got %b want %b", got6, want6);
        end
        n_checks++;
        if (saw_rom010 !== 1'b1) begin
            n_fail++;
            $display("FAIL gfx_rom_addr: rom_addr 0x010 seen=%0d want 1", saw_rom010);
        end
        n_checks++;
        if (line_errs(12) !== 0) begin
            n_fail++;
            $display("FAIL gfx_line: got %0d pixel errors want 0", line_errs(12));
        end
    endtask

    task automatic test_random_lines;
        int s;
        fill_mem(1, 8'h00, 8'h00);
        do_frame;
        s = 0;
        for (int k = 0; k < 5; k++) begin
            s = s + $urandom_range(1, 35);
            advance_to(s);
            cur_line++;
            do_line(1, 1, 0, 0);
            n_checks++;
            if (line_errs(s) !== 0) begin
                n_fail++;
                $display("FAIL random_line %0d: got %0d pixel errors want 0", s, line_errs(s));
            end
            n_checks++;
            if (ceb_cnt !== 64) begin
                n_fail++;
                $display("FAIL random_reads line %0d: got %0d want 64", s, ceb_cnt);
            end
        end
    endtask

    task automatic test_abort;
        logic [9:0] want_adb, got_adb;
        fill_mem(1, 8'h00, 8'h00);
        do_frame;
        advance_to($urandom_range(3, 150));
        cur_line += 2;
        do_line(1, 0, 1, 0);
        want_adb = 10'((cur_line / 12) * 64);
        got_adb = (adb_q.size() > 0) ? adb_q[0] : 10'h3FF;
        n_checks++;
        if (got_adb !== want_adb) begin
            n_fail++;
            $display("FAIL abort_addr: got %0d want %0d", got_adb, want_adb);
        end
        n_checks++;
        if (line_errs(cur_line) !== 0) begin
            n_fail++;
            $display("FAIL abort_line %0d: got %0d pixel errors want 0", cur_line, line_errs(cur_line));
        end
        n_checks++;
        if (ceb_cnt !== 64) begin
            n_fail++;
            $display("FAIL abort_reads: got %0d want 64", ceb_cnt);
        end
    endtask

    task automatic test_frame_with_line;
        advance_to(cur_line + 5);
        cur_line = 0;
        do_line(1, 0, 0, 1);
        n_checks++;
        if (line_errs(0) !== 0) begin
            n_fail++;
            $display("FAIL frame_line_together: got %0d pixel errors want 0", line_errs(0));
        end
    endtask

    task automatic test_reset_midline;
        bit found;
        fill_mem(1, 8'h00, 8'h00);
        do_frame;
        advance_to(5);
        line_start = 1'b1;
        tick;
        line_start = 1'b0;
        repeat (7) tick;
        active = 1'b1;
        pix_ce = 1'b1;
        found = 0;
        for (int k = 0; k < 200; k++) begin
            tick;
            if (ram_ceb === 1'b1) begin
                found = 1;
                break;
            end
        end
        n_checks++;
        if (found !== 1'b1) begin
            n_fail++;
            $display("FAIL midline_fetch: RAM read seen=%0d want 1", found);
        end
        #2;
        reset = 1'b1;
        #1;
        n_checks++;
        if ({pixel, pixel_de, ram_ceb} !== 3'b000) begin
            n_fail++;
            $display("FAIL midline_reset_out: got %b want 000", {pixel, pixel_de, ram_ceb});
        end
        n_checks++;
        if (rom_addr !== 11'd0) begin
            n_fail++;
            $display("FAIL midline_reset_rom: got %0h want 0", rom_addr);
        end
        active = 1'b0;
        repeat (2) tick;
        reset = 1'b0;
        tick;
    endtask

    initial begin
        test_reset;
        test_blank_frame;
        test_row_saturate;
        test_char_a;
        test_gfx_code;
        test_random_lines;
        test_abort;
        test_frame_with_line;
        test_reset_midline;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
